// File: rtl/morra_match_controller.sv
// Series sequencer for the MorraCinese core: collects one move per player, plays rounds
// on the core, tallies game results and declares the series winner.
module morra_match_controller #(
  parameter int SERIES_WINS  = 2,
  parameter int MAX_GAMES    = 3,
  parameter int MOVE_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cfg_max,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  output logic       p1_ready,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p2_ready,
  output logic [1:0] primo,
  output logic [1:0] secondo,
  output logic       inizia,
  input  logic [1:0] manche,
  input  logic [1:0] partita,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic [2:0] games_played,
  output logic [1:0] last_manche,
  output logic       busy,
  output logic       series_done,
  output logic [1:0] series_winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEWGAME, S_CONFIG, S_COLLECT, S_PLAY, S_GAMEEND, S_DONE
  } state_t;

  localparam logic [2:0] WINS_C     = 3'(SERIES_WINS);
  localparam logic [2:0] MAXG_C     = 3'(MAX_GAMES);
  localparam logic [7:0] TMO_LAST_C = 8'(MOVE_TIMEOUT - 1);

  state_t     state_r;
  logic [1:0] mv1_r, mv2_r, part_r;
  logic       got1_r, got2_r;
  logic [7:0] cnt_r;

  logic       take1_s, take2_s, pair_s, tmo_s, end_s;
  logic [2:0] sc1_nx_s, sc2_nx_s, games_nx_s;

  function automatic logic [1:0] winner_f(input logic [2:0] a, input logic [2:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  // Move acceptance; a 00 move is never latched so ready stays up for that player
  assign take1_s    = (state_r == S_COLLECT) && p1_valid && p1_ready && (p1_move != 2'b00);
  assign take2_s    = (state_r == S_COLLECT) && p2_valid && p2_ready && (p2_move != 2'b00);
  assign pair_s     = (got1_r || take1_s) && (got2_r || take2_s);
  assign tmo_s      = (got1_r ^ got2_r) && (cnt_r == TMO_LAST_C);
  assign sc1_nx_s   = ((part_r == 2'b01) && (score_p1 != 3'd7)) ? score_p1 + 3'd1 : score_p1;
  assign sc2_nx_s   = ((part_r == 2'b10) && (score_p2 != 3'd7)) ? score_p2 + 3'd1 : score_p2;
  assign games_nx_s = (games_played == 3'd7) ? 3'd7 : games_played + 3'd1;
  assign end_s      = (sc1_nx_s == WINS_C) || (sc2_nx_s == WINS_C) || (games_nx_s == MAXG_C);

  // Series FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      mv1_r         <= 2'b00;
      mv2_r         <= 2'b00;
      part_r        <= 2'b00;
      got1_r        <= 1'b0;
      got2_r        <= 1'b0;
      cnt_r         <= 8'd0;
      p1_ready      <= 1'b0;
      p2_ready      <= 1'b0;
      primo         <= 2'b00;
      secondo       <= 2'b00;
      inizia        <= 1'b0;
      score_p1      <= 3'd0;
      score_p2      <= 3'd0;
      games_played  <= 3'd0;
      last_manche   <= 2'b00;
      busy          <= 1'b0;
      series_done   <= 1'b0;
      series_winner <= 2'b00;
    end else if (start) begin
      state_r       <= S_NEWGAME;
      mv1_r         <= 2'b00;
      mv2_r         <= 2'b00;
      got1_r        <= 1'b0;
      got2_r        <= 1'b0;
      cnt_r         <= 8'd0;
      p1_ready      <= 1'b0;
      p2_ready      <= 1'b0;
      primo         <= 2'b00;
      secondo       <= 2'b00;
      inizia        <= 1'b1;
      score_p1      <= 3'd0;
      score_p2      <= 3'd0;
      games_played  <= 3'd0;
      busy          <= 1'b1;
      series_done   <= 1'b0;
      series_winner <= 2'b00;
    end else begin
      case (state_r)
        S_NEWGAME: begin
          inizia  <= 1'b0;
          primo   <= cfg_max[3:2];
          secondo <= cfg_max[1:0];
          state_r <= S_CONFIG;
        end
        S_CONFIG: begin
          primo    <= 2'b00;
          secondo  <= 2'b00;
          p1_ready <= 1'b1;
          p2_ready <= 1'b1;
          cnt_r    <= 8'd0;
          state_r  <= S_COLLECT;
        end
        S_COLLECT: begin
          if (take1_s) begin
            mv1_r  <= p1_move;
            got1_r <= 1'b1;
          end
          if (take2_s) begin
            mv2_r  <= p2_move;
            got2_r <= 1'b1;
          end
          if (pair_s || tmo_s) begin
            // A missing move is still 00 in its latch, which is the forced value
            primo    <= take1_s ? p1_move : mv1_r;
            secondo  <= take2_s ? p2_move : mv2_r;
            p1_ready <= 1'b0;
            p2_ready <= 1'b0;
            state_r  <= S_PLAY;
          end else begin
            p1_ready <= !(got1_r || take1_s);
            p2_ready <= !(got2_r || take2_s);
            cnt_r    <= (got1_r ^ got2_r) ? cnt_r + 8'd1 : 8'd0;
          end
        end
        S_PLAY: begin
          last_manche <= manche;
          part_r      <= partita;
          mv1_r       <= 2'b00;
          mv2_r       <= 2'b00;
          got1_r      <= 1'b0;
          got2_r      <= 1'b0;
          cnt_r       <= 8'd0;
          primo       <= 2'b00;
          secondo     <= 2'b00;
          if (partita == 2'b00) begin
            p1_ready <= 1'b1;
            p2_ready <= 1'b1;
            state_r  <= S_COLLECT;
          end else begin
            state_r  <= S_GAMEEND;
          end
        end
        S_GAMEEND: begin
          games_played <= games_nx_s;
          score_p1     <= sc1_nx_s;
          score_p2     <= sc2_nx_s;
          if (end_s) begin
            busy          <= 1'b0;
            series_done   <= 1'b1;
            series_winner <= winner_f(sc1_nx_s, sc2_nx_s);
            state_r       <= S_DONE;
          end else begin
            inizia  <= 1'b1;
            state_r <= S_NEWGAME;
          end
        end
        S_IDLE, S_DONE: begin
          state_r <= state_r;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
